// File: rtl/cache_fill_arbiter_if.sv
// Port bundle between the I/D caches, memory4c and the fill arbiter.
// master: arbiter side (misses, memory read data in; memory request, fill strobes out).
interface cache_fill_arbiter_if;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_grant;
  logic [15:0] fill_data;
  logic [15:0] fill_addr;
  logic        fill_we_i;
  logic        fill_we_d;
  logic        tag_we_i;
  logic        tag_we_d;
  logic        i_busy;
  logic        d_busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  mem_data_out, mem_data_valid,
    output mem_addr, mem_enable, mem_grant,
    output fill_data, fill_addr,
    output fill_we_i, fill_we_d, tag_we_i, tag_we_d,
    output i_busy, d_busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output mem_data_out, mem_data_valid,
    input  mem_addr, mem_enable, mem_grant,
    input  fill_data, fill_addr,
    input  fill_we_i, fill_we_d, tag_we_i, tag_we_d,
    input  i_busy, d_busy
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// I/D cache miss arbiter: issues block reads to memory4c, steers fill words.
// Ports: clk, rst (sync, active-high), bus (cache_fill_arbiter_if.master).
module cache_fill_arbiter #(
  parameter int WORDS = 8
) (
  input  logic clk,
  input  logic rst,
  cache_fill_arbiter_if.master bus
);
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] ISS_LAST = IW'(WORDS - 1);
  localparam logic [IW:0]   RCV_LAST = (IW+1)'(WORDS - 1);
  localparam logic [15:0]   MASK     = ~16'(2 * WORDS - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [IW-1:0] iss_cnt;
  logic [IW:0]   rcv_cnt;
  logic          owner;
  logic [15:0]   base;
  logic          filling;
  logic          wr;

  assign filling = (state == ISSUE) || (state == DRAIN);
  assign wr      = filling && bus.mem_data_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (bus.i_miss || bus.d_miss) nxt = ISSUE;
      ISSUE: if (iss_cnt == ISS_LAST) nxt = DRAIN;
      DRAIN: if (wr && rcv_cnt == RCV_LAST) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // base/owner are only loaded on the IDLE exit so
  // later miss-address changes cannot disturb a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_cnt <= '0;
      rcv_cnt <= '0;
      owner   <= 1'b0;
      base    <= '0;
    end else begin
      if (state == IDLE) begin
        iss_cnt <= '0;
        rcv_cnt <= '0;
        if (bus.i_miss) begin
          owner <= 1'b0;
          base  <= bus.i_miss_addr & MASK;
        end else if (bus.d_miss) begin
          owner <= 1'b1;
          base  <= bus.d_miss_addr & MASK;
        end
      end
      if (state == ISSUE) iss_cnt <= iss_cnt + 1'b1;
      if (wr)             rcv_cnt <= rcv_cnt + 1'b1;
      if (state == DONE) begin
        iss_cnt <= '0;
        rcv_cnt <= '0;
      end
    end
  end

  // Outputs are forced low while rst is held so the
  // parent sees a quiet port even before state settles.
  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_enable = 1'b0;
    bus.mem_grant  = 1'b0;
    bus.fill_data  = '0;
    bus.fill_addr  = '0;
    bus.fill_we_i  = 1'b0;
    bus.fill_we_d  = 1'b0;
    bus.tag_we_i   = 1'b0;
    bus.tag_we_d   = 1'b0;
    bus.i_busy     = 1'b0;
    bus.d_busy     = 1'b0;
    if (!rst) begin
      bus.fill_data = bus.mem_data_out;
      bus.mem_grant = (state != IDLE);
      bus.i_busy    = (state != IDLE) && !owner;
      bus.d_busy    = (state != IDLE) && owner;
      if (state == ISSUE) begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = base + 16'({iss_cnt, 1'b0});
      end
      unique case (1'b1)
        wr: begin
          bus.fill_addr = base + 16'({rcv_cnt[IW-1:0], 1'b0});
          bus.fill_we_i = !owner;
          bus.fill_we_d = owner;
        end
        (state == DONE): begin
          bus.fill_addr = base;
          bus.tag_we_i  = !owner;
          bus.tag_we_d  = owner;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle memory model.
// Checks every cycle of each fill against the block's fixed timeline.
module tb_cache_fill_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_arbiter_if bus();

  cache_fill_arbiter #(.WORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0]  pv;
  logic [15:0] pa [4];
  logic        spur;

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], bus.mem_enable};
      pa[0] <= bus.mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
  end

  always_comb begin
    bus.mem_data_valid = pv[3] | spur;
    if (pv[3])     bus.mem_data_out = 16'hA000 + {13'd0, pa[3][3:1]};
    else if (spur) bus.mem_data_out = 16'h5A5A;
    else           bus.mem_data_out = 16'h0000;
  end

  typedef struct packed {
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_grant;
    logic [15:0] fill_data;
    logic [15:0] fill_addr;
    logic        fwi;
    logic        fwd;
    logic        twi;
    logic        twd;
    logic        ib;
    logic        db;
  } out_t;

  typedef struct {
    logic        im;
    logic [15:0] ia;
    logic        dm;
    logic [15:0] da;
    bit          o1;
    logic [15:0] b1;
    bit          two;
    logic [15:0] b2;
  } vec_t;

  vec_t tv[5];
  int   nvec = 0;
  int   nfail = 0;

  function automatic out_t expect_at(int k, bit o, logic [15:0] b,
                                     logic [15:0] mdo);
    out_t e;
    e = '0;
    e.fill_data = mdo;
    if (k >= 1 && k <= 13) begin
      e.mem_grant = 1'b1;
      if (o) e.db = 1'b1;
      else   e.ib = 1'b1;
    end
    if (k >= 1 && k <= 8) begin
      e.mem_enable = 1'b1;
      e.mem_addr   = b + 16'(2 * (k - 1));
    end
    if (k >= 5 && k <= 12) begin
      e.fill_addr = b + 16'(2 * (k - 5));
      e.fill_data = 16'hA000 + 16'(k - 5);
      if (o) e.fwd = 1'b1;
      else   e.fwi = 1'b1;
    end
    if (k == 13) begin
      e.fill_addr = b;
      if (o) e.twd = 1'b1;
      else   e.twi = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int k, input bit o,
                     input logic [15:0] b, input bit zero);
    out_t g;
    out_t e;
    g = {bus.mem_addr, bus.mem_enable, bus.mem_grant, bus.fill_data,
         bus.fill_addr, bus.fill_we_i, bus.fill_we_d, bus.tag_we_i,
         bus.tag_we_d, bus.i_busy, bus.d_busy};
    e = zero ? out_t'('0) : expect_at(k, o, b, bus.mem_data_out);
    nvec++;
    if (g !== e) begin
      nfail++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, g, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run_fill(input string nm, input bit o,
                          input logic [15:0] b,
                          input logic [15:0] ia,
                          input logic [15:0] da);
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k == 6) begin
        bus.i_miss_addr = 16'h5556;
        bus.d_miss_addr = 16'hAAAA;
      end
      if (k == 13) begin
        bus.i_miss_addr = ia;
        bus.d_miss_addr = da;
        if (o) bus.d_miss = 1'b0;
        else   bus.i_miss = 1'b0;
      end
      #1;
      chk(nm, k, o, b, 1'b0);
    end
  endtask

  initial begin
    tv[0] = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1'b0, 16'h1230, 1'b0, 16'h0000};
    tv[1] = '{1'b0, 16'h0000, 1'b1, 16'h8002, 1'b1, 16'h8000, 1'b0, 16'h0000};
    tv[2] = '{1'b1, 16'h0040, 1'b1, 16'h8002, 1'b0, 16'h0040, 1'b1, 16'h8000};
    tv[3] = '{1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b1, 16'hFFF0, 1'b0, 16'h0000};
    tv[4] = '{1'b1, 16'h000F, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};

    spur            = 1'b0;
    bus.i_miss      = 1'b1;
    bus.i_miss_addr = 16'h0000;
    bus.d_miss      = 1'b0;
    bus.d_miss_addr = 16'h0000;

    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("reset_hold", 0, 1'b0, 16'h0, 1'b1);
    end
    cyc();
    rst = 1'b0;
    #1;
    chk("reset_release", 0, 1'b0, 16'h0, 1'b0);
    run_fill("reset_fill", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    cyc();
    #1;
    chk("reset_idle", 0, 1'b0, 16'h0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      cyc();
      bus.i_miss      = tv[i].im;
      bus.i_miss_addr = tv[i].ia;
      bus.d_miss      = tv[i].dm;
      bus.d_miss_addr = tv[i].da;
      #1;
      chk("vec_sample", 0, tv[i].o1, tv[i].b1, 1'b0);
      run_fill("vec_fill1", tv[i].o1, tv[i].b1, tv[i].ia, tv[i].da);
      if (tv[i].two) begin
        cyc();
        #1;
        chk("vec_gap", 0, 1'b1, tv[i].b2, 1'b0);
        run_fill("vec_fill2", 1'b1, tv[i].b2, tv[i].ia, tv[i].da);
      end
      cyc();
      #1;
      chk("vec_idle", 0, 1'b0, 16'h0, 1'b0);
    end

    for (int i = 0; i < 2; i++) begin
      cyc();
      spur = 1'b1;
      #1;
      chk("spur_idle", 0, 1'b0, 16'h0, 1'b0);
    end
    cyc();
    spur = 1'b0;
    #1;
    chk("spur_after", 0, 1'b0, 16'h0, 1'b0);

    cyc();
    bus.i_miss      = 1'b1;
    bus.i_miss_addr = 16'h2228;
    #1;
    chk("rmid_sample", 0, 1'b0, 16'h2220, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      #1;
      chk("rmid_part", k, 1'b0, 16'h2220, 1'b0);
    end
    cyc();
    rst = 1'b1;
    #1;
    chk("rmid_rst", 0, 1'b0, 16'h0, 1'b1);
    cyc();
    rst = 1'b0;
    #1;
    chk("rmid_restart", 0, 1'b0, 16'h2220, 1'b0);
    run_fill("rmid_fill", 1'b0, 16'h2220, 16'h2228, 16'h0000);
    cyc();
    #1;
    chk("rmid_idle", 0, 1'b0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Miss-handling controller between the I/D caches and the shared four-cycle main memory (memory4c). It arbitrates between an I-cache miss and a D-cache miss, issues the eight word addresses of the missing 16-byte block to memory, and steers each returned word into the requesting cache's data array. It then writes that cache's tag/valid entry once the block is complete. While a fill is in progress it owns the memory read port; the parent muxes memory address/enable from this block whenever `mem_grant` is high.

## Interface
- `WORDS`, 8: 16-bit words per cache block (block = 16 bytes, byte-addressed).
- `MEM_LAT`, 4: memory4c read latency in cycles, address-to-`data_valid`.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_miss` in 1: I-cache miss (cache stall line).
- `i_miss_addr` in 16: I-cache missed byte address.
- `d_miss` in 1: D-cache miss.
- `d_miss_addr` in 16: D-cache missed byte address.
- `mem_data_out` in 16: memory4c read data.
- `mem_data_valid` in 1: memory4c data valid.
- `mem_addr` out 16: address to memory4c while granted.
- `mem_enable` out 1: memory read enable.
- `mem_grant` out 1: block owns the memory port (state != IDLE).
- `fill_data` out 16: word to write into the cache data array (= `mem_data_out`).
- `fill_addr` out 16: byte address of `fill_data` (base + 2*word index).
- `fill_we_i` / `fill_we_d` out 1: data-array write strobe to the I / D cache.
- `tag_we_i` / `tag_we_d` out 1: tag+valid write strobe to the I / D cache.
- `i_busy` / `d_busy` out 1: fill for the I / D cache in progress.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Counters and registers:
  - 3-bit `iss_cnt`: addresses issued.
  - 4-bit `rcv_cnt`: words received (0..8).
  - 1-bit `owner`: 0 = I, 1 = D.
  - 16-bit `base`: block address.
- IDLE:
  - If `i_miss`: owner=I, base=`i_miss_addr & 16'hFFF0`, go to ISSUE.
  - Else if `d_miss`: owner=D, base from `d_miss_addr`, go to ISSUE.
  - I has fixed priority. A D miss still asserted is served on the next IDLE.
- ISSUE:
  - `mem_enable`=1, `mem_addr` = base + {iss_cnt,1'b0}; `iss_cnt` increments each cycle.
  - After the 8th address (iss_cnt==7), go to DRAIN.
- ISSUE/DRAIN, each cycle with `mem_data_valid`=1:
  - Assert the owner's `fill_we_*`; `fill_addr` = base + {rcv_cnt[2:0],1'b0}.
  - `rcv_cnt` increments. When it reaches 8, go to DONE.
- DONE:
  - One cycle. Assert the owner's `tag_we_*` with `fill_addr`=base.
  - Go to IDLE. Counters clear.
- Latching and gating:
  - `base`/`owner` are latched on the IDLE exit. Later changes to `*_miss_addr` or `*_miss` are ignored until IDLE.
  - `mem_data_valid` in IDLE or DONE is ignored: no write strobe.
- Reset values: every output 0; state IDLE; counters 0.
- Reset mid-fill: return to IDLE. No `tag_we` is issued, so the partial block stays invalid. A still-asserted miss restarts the whole fill.
- Memory writes: none are issued. Store write-through is outside this block, and the parent gives stores the port only when `mem_grant`=0.

## Timing
- Cycle 0: IDLE with a miss sampled.
- Cycles 1-8: ISSUE, `mem_enable`=1, addresses base+0..base+14.
- Cycles 5-12: `mem_data_valid`, fill writes for words 0..7. DRAIN covers cycles 9-12.
- Cycle 13: DONE, tag write.
- Cycle 14: IDLE. The cache now hits, so its miss is low; with a D miss pending, the D fill starts ISSUE at cycle 15.
- Miss penalty is 14 cycles per block.
- `*_busy` and `mem_grant` are high in cycles 1-13.
- `fill_data` and `fill_we_*` are combinational from `mem_data_valid`; there is no extra latency.
- Word index wraps within the block only; no carry into the tag bits.

## Test plan
- Reset with `i_miss`=1 held: all outputs 0 while `rst`=1. First cycle after release → IDLE samples the miss; `mem_addr`=0x0000..0x000E in cycles 1-8.
- I miss at 0x1236 → base 0x1230. `fill_we_i` for 8 cycles with `fill_addr` 0x1230..0x123E; `tag_we_i` at cycle 13; `fill_we_d`/`tag_we_d` never assert.
- `i_miss` (0x0040) and `d_miss` (0x8002) asserted together → I block filled first. D fill issues 0x8000 at cycle 15; `tag_we_d` at cycle 27.
- Memory returns 0xA000+index. Change `d_miss_addr` mid-fill → written data and addresses follow the latched base unchanged.
- Spurious `mem_data_valid` in IDLE → no strobes. `rst` pulsed at cycle 7 of a fill → outputs 0 next cycle, no `tag_we`, fill restarts from word 0.
